// File: rtl/hazard_controller.sv
// Pipeline sequencing for the 5-stage datapath: tracks in-flight destinations and drives stall/flush/forward/bypass.
// Controls are combinational from shadow state and inputs; state advances one clk later; freeze holds everything.
module hazard_controller #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  mem_redirect,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_bubble,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  id_bypass_a,
  output logic                  id_bypass_b,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  reg_write;
    logic                  mem_read;
  } stage_t;

  typedef struct packed {
    stage_t                s;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic                  use_rs;
    logic                  use_rt;
  } ex_t;

  ex_t    ex_q;
  stage_t mem_q;
  stage_t wb_q;
  logic   luh;

  // Register 0 is hard-wired, so a write to it never produces a match.
  function automatic logic hit(input stage_t e, input logic [REG_ADDR_W-1:0] r);
    return e.valid & e.reg_write & (e.dest != '0) & (e.dest == r);
  endfunction

  // A load still in MEM has no data yet, so only WB may feed it forward.
  function automatic logic [1:0] fwd_sel(input logic use_r, input logic [REG_ADDR_W-1:0] r,
                                         input stage_t m, input stage_t w);
    if (use_r & hit(m, r) & !m.mem_read) return 2'b01;
    else if (use_r & hit(w, r))          return 2'b10;
    else                                 return 2'b00;
  endfunction

  assign luh = id_valid & ex_q.s.mem_read &
               ((id_use_rs & hit(ex_q.s, id_rs)) | (id_use_rt & hit(ex_q.s, id_rt)));

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    forward_a   = 2'b00;
    forward_b   = 2'b00;
    id_bypass_a = 1'b0;
    id_bypass_b = 1'b0;
    if (rst) begin
      if (freeze) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end else if (mem_redirect) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (luh) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      if (ex_q.s.valid) begin
        forward_a = fwd_sel(ex_q.use_rs, ex_q.rs, mem_q, wb_q);
        forward_b = fwd_sel(ex_q.use_rt, ex_q.rt, mem_q, wb_q);
      end
      id_bypass_a = id_use_rs & hit(wb_q, id_rs);
      id_bypass_b = id_use_rt & hit(wb_q, id_rt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else if (!freeze) begin
      wb_q <= mem_q;
      if (mem_redirect) begin
        ex_q  <= '0;
        mem_q <= '0;
        if (flush_count != {CNT_W{1'b1}}) flush_count <= flush_count + CNT_W'(1);
      end else if (luh) begin
        ex_q  <= '0;
        mem_q <= ex_q.s;
        if (stall_count != {CNT_W{1'b1}}) stall_count <= stall_count + CNT_W'(1);
      end else begin
        mem_q            <= ex_q.s;
        ex_q.s.valid     <= id_valid;
        ex_q.s.dest      <= id_dest;
        ex_q.s.reg_write <= id_reg_write;
        ex_q.s.mem_read  <= id_mem_read;
        ex_q.rs          <= id_rs;
        ex_q.rt          <= id_rt;
        ex_q.use_rs      <= id_use_rs;
        ex_q.use_rt      <= id_use_rt;
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed vector table plus randomized run against an instruction-level pipeline model.
module tb_hazard_controller;

  localparam int RW = 5;
  localparam int CW = 2;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, freeze, id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read, mem_redirect;
  logic [RW-1:0] id_rs, id_rt, id_dest;
  logic          pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush;
  logic [1:0]    forward_a, forward_b;
  logic          id_bypass_a, id_bypass_b;
  logic [CW-1:0] stall_count, flush_count;

  hazard_controller #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .mem_redirect(mem_redirect), .pc_write(pc_write),
    .ifid_write(ifid_write), .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .forward_a(forward_a),
    .forward_b(forward_b), .id_bypass_a(id_bypass_a), .id_bypass_b(id_bypass_b),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  typedef struct packed {
    bit idv; bit [4:0] rs; bit [4:0] rt; bit urs; bit urt; bit [4:0] dest; bit rw; bit mr;
  } id_t;

  typedef struct {
    bit rst; bit frz; bit redir; id_t id;
    bit pcw; bit bub; bit fl; bit [1:0] fa; bit [1:0] fb; bit ba; bit bb; int sc; int fc;
  } vec_t;

  typedef struct packed {
    bit valid; bit [4:0] dest; bit rw; bit mr; bit [4:0] rs; bit [4:0] rt; bit urs; bit urt;
  } ent_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  ent_t pq[$];
  int m_sc, m_fc;

  function automatic id_t ins(bit idv, bit [4:0] rs, bit [4:0] rt, bit urs, bit urt,
                              bit [4:0] dest, bit rw, bit mr);
    id_t r;
    r.idv = idv; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt; r.dest = dest; r.rw = rw; r.mr = mr;
    return r;
  endfunction

  function automatic vec_t v(bit rs_n, bit frz, bit redir, id_t id, bit pcw, bit bub, bit fl,
                             bit [1:0] fa, bit [1:0] fb, bit ba, bit bb, int sc, int fc);
    vec_t r;
    r.rst = rs_n; r.frz = frz; r.redir = redir; r.id = id; r.pcw = pcw; r.bub = bub; r.fl = fl;
    r.fa = fa; r.fb = fb; r.ba = ba; r.bb = bb; r.sc = sc; r.fc = fc;
    return r;
  endfunction

  task automatic drive(bit rs_n, bit frz, bit redir, id_t id);
    rst = rs_n; freeze = frz; mem_redirect = redir;
    id_valid = id.idv; id_rs = id.rs; id_rt = id.rt; id_use_rs = id.urs; id_use_rt = id.urt;
    id_dest = id.dest; id_reg_write = id.rw; id_mem_read = id.mr;
  endtask

  task automatic cmp(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_all(bit pcw, bit bub, bit fl, bit [1:0] fa, bit [1:0] fb,
                         bit ba, bit bb, int sc, int fc);
    cmp("pc_write", pc_write, pcw);
    cmp("ifid_write", ifid_write, pcw);
    cmp("idex_bubble", idex_bubble, bub);
    cmp("ifid_flush", ifid_flush, fl);
    cmp("idex_flush", idex_flush, fl);
    cmp("exmem_flush", exmem_flush, fl);
    cmp("forward_a", forward_a, fa);
    cmp("forward_b", forward_b, fb);
    cmp("id_bypass_a", id_bypass_a, ba);
    cmp("id_bypass_b", id_bypass_b, bb);
    cmp("stall_count", stall_count, sc);
    cmp("flush_count", flush_count, fc);
  endtask

  // Model: pq[0] is the instruction in EX, pq[1] in MEM, pq[2] in WB.
  function automatic bit writes(ent_t e, bit [4:0] r);
    return e.valid && e.rw && e.dest != 0 && e.dest == r;
  endfunction

  function automatic bit [1:0] src_for(bit use_r, bit [4:0] r);
    if (!pq[0].valid || !use_r) return 2'd0;
    if (writes(pq[1], r) && !pq[1].mr) return 2'd1;
    if (writes(pq[2], r)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit model_luh(id_t id);
    return id.idv && pq[0].mr &&
           ((id.urs && writes(pq[0], id.rs)) || (id.urt && writes(pq[0], id.rt)));
  endfunction

  task automatic model_check(bit rs_n, bit frz, bit redir, id_t id);
    bit pcw, bub, fl, ba, bb;
    bit [1:0] fa, fb;
    pcw = 1; bub = 0; fl = 0; fa = 0; fb = 0; ba = 0; bb = 0;
    if (rs_n) begin
      if (frz) pcw = 0;
      else if (redir) fl = 1;
      else if (model_luh(id)) begin pcw = 0; bub = 1; end
      fa = src_for(pq[0].urs, pq[0].rs);
      fb = src_for(pq[0].urt, pq[0].rt);
      ba = id.urs && writes(pq[2], id.rs);
      bb = id.urt && writes(pq[2], id.rt);
    end
    cmp_all(pcw, bub, fl, fa, fb, ba, bb, m_sc, m_fc);
  endtask

  task automatic model_reset();
    ent_t inv;
    inv = '0;
    pq.delete();
    repeat (3) pq.push_back(inv);
    m_sc = 0; m_fc = 0;
  endtask

  task automatic model_clock(bit rs_n, bit frz, bit redir, id_t id);
    ent_t inv, nw;
    inv = '0;
    if (!rs_n) begin
      model_reset();
    end else if (!frz) begin
      if (redir) begin
        pq.push_front(inv); void'(pq.pop_back()); pq[1] = inv;
        if (m_fc < SAT) m_fc++;
      end else if (model_luh(id)) begin
        pq.push_front(inv); void'(pq.pop_back());
        if (m_sc < SAT) m_sc++;
      end else begin
        nw.valid = id.idv; nw.dest = id.dest; nw.rw = id.rw; nw.mr = id.mr;
        nw.rs = id.rs; nw.rt = id.rt; nw.urs = id.urs; nw.urt = id.urt;
        pq.push_front(nw); void'(pq.pop_back());
      end
    end
  endtask

  initial begin
    id_t NOP, LW8, ADD9, ADD5, SUB6, OR7, W0, R0, W4, R4, LW12, C12, FZ, R11, LWB, C8;
    id_t rid;
    bit rr, rf, rd;
    NOP  = ins(0, 0, 0, 0, 0, 0, 0, 0);
    LW8  = ins(1, 2, 0, 1, 0, 8, 1, 1);
    ADD9 = ins(1, 8, 3, 1, 1, 9, 1, 0);
    ADD5 = ins(1, 1, 2, 1, 1, 5, 1, 0);
    SUB6 = ins(1, 5, 5, 1, 1, 6, 1, 0);
    OR7  = ins(1, 5, 6, 1, 1, 7, 1, 0);
    W0   = ins(1, 1, 2, 1, 1, 0, 1, 0);
    R0   = ins(1, 0, 0, 1, 1, 10, 1, 0);
    W4   = ins(1, 0, 0, 1, 1, 4, 1, 0);
    R4   = ins(1, 4, 1, 1, 1, 11, 1, 0);
    LW12 = ins(1, 1, 0, 1, 0, 12, 1, 1);
    C12  = ins(1, 12, 0, 1, 0, 13, 1, 0);
    FZ   = ins(1, 1, 2, 1, 1, 14, 1, 0);
    R11  = ins(1, 11, 2, 1, 1, 14, 1, 0);
    LWB  = ins(1, 1, 0, 1, 0, 8, 1, 1);
    C8   = ins(1, 8, 0, 1, 0, 9, 1, 0);

    // reset held with freeze and redirect asserted
    tbl.push_back(v(0, 1, 1, LW8,  1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, LW8,  1, 0, 0, 0, 0, 0, 0, 0, 0));
    // load-use: one stall, then WB forward
    tbl.push_back(v(1, 0, 0, LW8,  1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, ADD9, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, ADD9, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 0, 0, NOP,  1, 0, 0, 2, 0, 0, 0, 1, 0));
    // ALU chain
    tbl.push_back(v(1, 0, 0, ADD5, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 0, 0, SUB6, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 0, 0, OR7,  1, 0, 0, 1, 1, 0, 0, 1, 0));
    tbl.push_back(v(1, 0, 0, NOP,  1, 0, 0, 2, 1, 0, 0, 1, 0));
    // $0 never matches; WB-to-ID bypass for one cycle
    tbl.push_back(v(1, 0, 0, W0,   1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 0, 0, R0,   1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 0, 0, NOP,  1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 0, 0, W4,   1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 0, 0, NOP,  1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 0, 0, NOP,  1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 0, 0, R4,   1, 0, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(v(1, 0, 0, R4,   1, 0, 0, 0, 0, 0, 0, 1, 0));
    // redirect wins over a coincident load-use
    tbl.push_back(v(1, 0, 0, LW12, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 0, 1, C12,  1, 0, 1, 0, 0, 0, 0, 1, 0));
    // freeze swallows redirect, shadow holds (WB still supplies $11)
    tbl.push_back(v(1, 1, 1, FZ,   0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(1, 1, 1, FZ,   0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(1, 1, 1, FZ,   0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(1, 0, 1, R11,  1, 0, 1, 0, 0, 1, 0, 1, 1));
    tbl.push_back(v(1, 0, 0, NOP,  1, 0, 0, 0, 0, 0, 0, 1, 2));
    // five more stalls saturate the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      tbl.push_back(v(1, 0, 0, LWB, 1, 0, 0, (i == 0) ? 2'd0 : 2'd2, 0, 0, 0,
                      (1 + i > SAT) ? SAT : 1 + i, 2));
      tbl.push_back(v(1, 0, 0, C8,  0, 1, 0, 0, 0, 0, 0, (1 + i > SAT) ? SAT : 1 + i, 2));
      tbl.push_back(v(1, 0, 0, C8,  1, 0, 0, 0, 0, 0, 0, (2 + i > SAT) ? SAT : 2 + i, 2));
    end
    // reset mid-sequence overrides redirect/load-use
    tbl.push_back(v(1, 0, 0, LWB,  1, 0, 0, 2, 0, 0, 0, SAT, 2));
    tbl.push_back(v(0, 0, 1, C8,   1, 0, 0, 0, 0, 0, 0, SAT, 2));
    tbl.push_back(v(1, 0, 0, NOP,  1, 0, 0, 0, 0, 0, 0, 0, 0));

    drive(0, 0, 0, NOP);
    @(posedge clk); #1;
    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].frz, tbl[k].redir, tbl[k].id);
      #2;
      cmp_all(tbl[k].pcw, tbl[k].bub, tbl[k].fl, tbl[k].fa, tbl[k].fb,
              tbl[k].ba, tbl[k].bb, tbl[k].sc, tbl[k].fc);
      @(posedge clk); #1;
    end

    model_reset();
    for (int n = 0; n < 3000; n++) begin
      rr = ($urandom_range(0, 63) != 0);
      rf = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 9) == 0);
      rid = ins($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      drive(rr, rf, rd, rid);
      #2;
      model_check(rr, rf, rd, rid);
      @(posedge clk);
      model_clock(rr, rf, rd, rid);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
